// File: rtl/axi_sha256_intr_slave_if.sv
// AXI4-Lite bundle for the SHA-256 interrupt controller register port.
// The master modport drives requests; the slave modport drives responses.
interface axi_sha256_intr_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_sha256_intr_slave.sv
// AXI4-Lite interrupt controller for the SHA-256 core: GIE/IER/ISR/IAR/IPR
// registers and a registered irq output.
// Optional feature macro: INTR_SRC_EDGE_EN (ISR sets on rising edges of
// intr_src instead of on every high cycle).
module axi_sha256_intr_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_OF_INTR      = 1,
  parameter int C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axi_sha256_intr_slave_if.slave   s_axi,
  input  logic [C_NUM_OF_INTR-1:0] intr_src,
  output logic                     irq
);

  localparam int   N     = C_NUM_OF_INTR;
  localparam int   DW    = C_S_AXI_DATA_WIDTH;
  localparam int   SW    = DW / 8;
  localparam logic IrqOn = (C_IRQ_ACTIVE_STATE != 0);

  typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RResp} r_state_e;

  w_state_e      r_wstate;
  r_state_e      r_rstate;
  logic          r_awready, r_wready, r_bvalid;
  logic          r_arready, r_rvalid;
  logic [2:0]    r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic [DW-1:0] r_rdata;

  logic          r_gie;
  logic [N-1:0]  r_ier;
  logic [N-1:0]  r_isr;
  logic          r_irq;

  logic          w_aw_hs, w_w_hs, w_ar_hs;
  logic          w_wr_en;
  logic [2:0]    w_wr_addr;
  logic [DW-1:0] w_wr_data;
  logic [SW-1:0] w_wr_strb;
  logic [DW-1:0] w_wmask;
  logic [DW-1:0] w_wbits;
  logic [N-1:0]  w_ack;
  logic [N-1:0]  w_event;
  logic [DW-1:0] w_rd_val;
  logic          w_unused;

  assign w_aw_hs = r_awready & s_axi.S_AXI_AWVALID;
  assign w_w_hs  = r_wready  & s_axi.S_AXI_WVALID;
  assign w_ar_hs = r_arready & s_axi.S_AXI_ARVALID;

  // Byte-offset bits and protection fields carry no meaning here.
  assign w_unused = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                      s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign irq                 = r_irq;

  // Select the write that commits this cycle: whichever half arrives last is
  // taken straight from the bus, the earlier half from its holding register.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_awaddr;
    w_wr_data = r_wdata;
    w_wr_strb = r_wstrb;
    case (r_wstate)
      WIdle: begin
        w_wr_en   = w_aw_hs & w_w_hs;
        w_wr_addr = s_axi.S_AXI_AWADDR[4:2];
        w_wr_data = s_axi.S_AXI_WDATA;
        w_wr_strb = s_axi.S_AXI_WSTRB;
      end
      WAddr: begin
        w_wr_en   = w_w_hs;
        w_wr_data = s_axi.S_AXI_WDATA;
        w_wr_strb = s_axi.S_AXI_WSTRB;
      end
      WData: begin
        w_wr_en   = w_aw_hs;
        w_wr_addr = s_axi.S_AXI_AWADDR[4:2];
      end
      default: ;
    endcase
  end

  // Expand byte strobes into a bit mask.
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < SW; b++) begin
      w_wmask[8*b +: 8] = {8{w_wr_strb[b]}};
    end
  end

  assign w_wbits = w_wr_data & w_wmask;
  assign w_ack   = (w_wr_en && w_wr_addr == 3'd3) ? w_wbits[N-1:0] : '0;

`ifdef INTR_SRC_EDGE_EN
  logic [N-1:0] r_src_q;

  // Previous-cycle source levels for rising-edge detection.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_src_q <= '0;
    else        r_src_q <= intr_src;
  end

  assign w_event = intr_src & ~r_src_q;
`else
  assign w_event = intr_src;
`endif

  // Write channel FSM: accept AW and W in either order, one write at a time.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate  <= WIdle;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        WIdle: begin
          r_awready <= s_axi.S_AXI_AWVALID & ~r_awready;
          r_wready  <= s_axi.S_AXI_WVALID & ~r_wready;
          if (w_aw_hs && w_w_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_wstate  <= WResp;
          end else if (w_aw_hs) begin
            r_awaddr <= s_axi.S_AXI_AWADDR[4:2];
            r_wstate <= WAddr;
          end else if (w_w_hs) begin
            r_wdata  <= s_axi.S_AXI_WDATA;
            r_wstrb  <= s_axi.S_AXI_WSTRB;
            r_wstate <= WData;
          end
        end
        WAddr: begin
          r_awready <= 1'b0;
          r_wready  <= s_axi.S_AXI_WVALID & ~r_wready;
          if (w_w_hs) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_wstate <= WResp;
          end
        end
        WData: begin
          r_wready  <= 1'b0;
          r_awready <= s_axi.S_AXI_AWVALID & ~r_awready;
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b1;
            r_wstate  <= WResp;
          end
        end
        default: begin
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          if (s_axi.S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
            r_wstate <= WIdle;
          end
        end
      endcase
    end
  end

  // Read data mux; unmapped and write-only offsets read as zero.
  always_comb begin
    w_rd_val = '0;
    case (s_axi.S_AXI_ARADDR[4:2])
      3'd0:    w_rd_val[0]     = r_gie;
      3'd1:    w_rd_val[N-1:0] = r_ier;
      3'd2:    w_rd_val[N-1:0] = r_isr;
      3'd4:    w_rd_val[N-1:0] = r_isr & r_ier;
      default: ;
    endcase
  end

  // Read channel FSM: registered RDATA held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rstate  <= RIdle;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        RIdle: begin
          r_arready <= s_axi.S_AXI_ARVALID & ~r_arready;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rdata   <= w_rd_val;
            r_rvalid  <= 1'b1;
            r_rstate  <= RResp;
          end
        end
        default: begin
          r_arready <= 1'b0;
          if (s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
            r_rstate <= RIdle;
          end
        end
      endcase
    end
  end

  // Control and status registers; a new event beats a same-cycle ack.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_gie <= 1'b0;
      r_ier <= '0;
      r_isr <= '0;
    end else begin
      if (w_wr_en && w_wr_addr == 3'd0 && w_wr_strb[0]) r_gie <= w_wr_data[0];
      if (w_wr_en && w_wr_addr == 3'd1) begin
        r_ier <= (r_ier & ~w_wmask[N-1:0]) | w_wbits[N-1:0];
      end
      r_isr <= (r_isr & ~w_ack) | w_event;
    end
  end

  // Registered interrupt output.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_irq <= ~IrqOn;
    else        r_irq <= (r_gie && |(r_isr & r_ier)) ? IrqOn : ~IrqOn;
  end

endmodule

// File: tb/tb_axi_sha256_intr_slave.sv
// Self-checking bench for axi_sha256_intr_slave: directed steps followed by
// randomized register traffic compared against a register-level model.
module tb_axi_sha256_intr_slave;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] intr_src = '0;
  logic         irq;
  int           checks = 0;
  int           errors = 0;

  // Reference model state
  logic         m_gie;
  logic [N-1:0] m_ier;
  logic [N-1:0] m_isr;

  axi_sha256_intr_slave_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  axi_sha256_intr_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .C_NUM_OF_INTR     (N),
    .C_IRQ_ACTIVE_STATE(1)
  ) dut (
    .ACLK    (clk),
    .ARESET  (rst),
    .s_axi   (bus),
    .intr_src(intr_src),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] st);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{st[b]}};
    return m;
  endfunction

  task automatic model_reset();
    m_gie = 1'b0;
    m_ier = '0;
    m_isr = '0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st);
    logic [31:0] mk;
    logic [31:0] md;
    mk = strb_mask(st);
    md = d & mk;
    case (a[4:2])
      3'd0: if (st[0]) m_gie = d[0];
      3'd1: m_ier = (m_ier & ~mk[N-1:0]) | md[N-1:0];
      3'd3: m_isr = m_isr & ~md[N-1:0];
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    case (a[4:2])
      3'd0: v[0] = m_gie;
      3'd1: v[N-1:0] = m_ier;
      3'd2: v[N-1:0] = m_isr;
      3'd4: v[N-1:0] = m_isr & m_ier;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic model_irq();
    return (m_gie && (m_isr & m_ier) != '0) ? 1'b1 : 1'b0;
  endfunction

  // Address and data phases; returns on the negedge right after the commit edge.
  task automatic write_req(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int w_lead, output bit ok);
    bit aw_p, w_p, aw_hs, w_hs;
    int n;
    bus.S_AXI_AWADDR = a;
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = st;
    bus.S_AXI_WVALID = 1'b1;
    aw_p = 1'b1;
    w_p  = 1'b1;
    n    = 0;
    while ((aw_p || w_p) && n < 40) begin
      if (aw_p && n >= w_lead) bus.S_AXI_AWVALID = 1'b1;
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge clk);
      if (aw_hs) begin bus.S_AXI_AWVALID = 1'b0; aw_p = 1'b0; end
      if (w_hs)  begin bus.S_AXI_WVALID  = 1'b0; w_p  = 1'b0; end
      n++;
    end
    ok = !(aw_p || w_p);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  // Response phase: hold BREADY low for b_delay cycles, then count stray BVALIDs.
  task automatic write_resp(input int b_delay, output int hi, output int extra, output bit ok);
    int n;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
    ok = bus.S_AXI_BVALID;
    hi = 0;
    for (int i = 0; i < b_delay; i++) begin
      if (bus.S_AXI_BVALID && bus.S_AXI_BRESP == 2'b00) hi++;
      @(negedge clk);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.S_AXI_BVALID) extra++;
      @(negedge clk);
    end
  endtask

  task automatic check_resp(input string tag, input int b_delay);
    int hi, extra;
    bit ok;
    write_resp(b_delay, hi, extra, ok);
    check({tag, "_bvalid"}, 32'(ok), 32'd1);
    check({tag, "_bhold"}, hi, b_delay);
    check({tag, "_bsingle"}, extra, 0);
  endtask

  task automatic do_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int w_lead, input int b_delay);
    bit ok;
    write_req(a, d, st, w_lead, ok);
    check({tag, "_hs"}, 32'(ok), 32'd1);
    model_write(a, d, st);
    check_resp(tag, b_delay);
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r,
                         output bit ok);
    int n;
    bit hs;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 20) begin
      hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(negedge clk);
      n++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
    ok = bus.S_AXI_RVALID;
    d  = bus.S_AXI_RDATA;
    r  = bus.S_AXI_RRESP;
    if (ok) begin
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
    end
  endtask

  task automatic check_read(input string tag, input logic [4:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    bit          ok;
    do_read(a, d, r, ok);
    check({tag, "_rvalid"}, 32'(ok), 32'd1);
    check(tag, d, model_read(a));
    check({tag, "_rresp"}, 32'(r), 32'd0);
  endtask

  // One-cycle event pulse; the model records it as sampled.
  task automatic pulse(input logic [N-1:0] v);
    intr_src = v;
    @(negedge clk);
    intr_src = '0;
    m_isr = m_isr | v;
  endtask

  initial begin
    bit          ok;
    int          op;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  st;

    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_handshake",
          32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
               bus.S_AXI_RVALID}), 32'd0);
    check("reset_rdata", bus.S_AXI_RDATA, 32'd0);
    check("reset_resp", 32'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_read("rd_gie_rst", 5'h00);
    check_read("rd_ier_rst", 5'h04);
    check_read("rd_isr_rst", 5'h08);
    check_read("rd_ipr_rst", 5'h10);

    // Enable and raise an event: irq two edges after sampling
    do_write("wr_gie", 5'h00, 32'h1, 4'hF, 0, 0);
    do_write("wr_ier", 5'h04, 32'h1, 4'hF, 0, 0);
    pulse(4'b0001);
    check("irq_lat1", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_lat2", 32'(irq), 32'd1);
    check_read("rd_ipr_evt", 5'h10);

    // Ack: irq drops one edge after the commit
    write_req(5'h0C, 32'h1, 4'hF, 0, ok);
    check("iar_hs", 32'(ok), 32'd1);
    model_write(5'h0C, 32'h1, 4'hF);
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'd0);
    check_resp("iar", 0);
    check_read("rd_ipr_clr", 5'h10);

    // Event in the same cycle the ack commits: the set wins
    pulse(4'b0001);
    @(negedge clk);
    bus.S_AXI_AWADDR  = 5'h0C;
    bus.S_AXI_WDATA   = 32'h1;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    @(negedge clk);
    check("race_ready", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'd3);
    intr_src = 4'b0001;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    intr_src = '0;
    model_write(5'h0C, 32'h1, 4'hF);
    m_isr = m_isr | 4'b0001;
    check_resp("race", 0);
    check_read("rd_isr_race", 5'h08);
    check("irq_race", 32'(irq), 32'(model_irq()));
    do_write("race_clr", 5'h0C, 32'h1, 4'hF, 0, 0);
    check("irq_race_clr", 32'(irq), 32'(model_irq()));

    // W three cycles ahead of AW, BREADY held low four cycles
    do_write("skew", 5'h04, 32'h5, 4'hF, 3, 4);
    check_read("rd_ier_skew", 5'h04);

    // Unmapped write is ignored, reads zero
    do_write("unmap", 5'h18, 32'hFFFF_FFFF, 4'hF, 0, 0);
    check_read("rd_unmap", 5'h18);
    check_read("rd_gie_unmap", 5'h00);
    check_read("rd_ier_unmap", 5'h04);

    // Strobes: a byte that does not hold IER bits leaves IER alone
    do_write("strb_hi", 5'h04, 32'h0000_0A0A, 4'b0010, 1, 1);
    check_read("rd_ier_strb_hi", 5'h04);
    do_write("strb_lo", 5'h04, 32'h0000_0A0A, 4'b0001, 0, 2);
    check_read("rd_ier_strb_lo", 5'h04);

    // Randomized traffic against the model
    for (int it = 0; it < 48; it++) begin
      op = $urandom_range(0, 3);
      a  = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d  = $urandom;
      st = 4'($urandom_range(0, 15));
      case (op)
        0: do_write("rnd_wr", a, d, st, $urandom_range(0, 3), $urandom_range(0, 2));
        1: do_write("rnd_wr_ctl", {3'($urandom_range(0, 1)), 2'b00}, d, 4'hF, 0, 0);
        2: pulse(N'($urandom_range(0, 15)));
        default: check_read("rnd_rd", a);
      endcase
      repeat (2) @(negedge clk);
      check("rnd_irq", 32'(irq), 32'(model_irq()));
    end
    check_read("rnd_isr_end", 5'h08);
    check_read("rnd_ipr_end", 5'h10);

    // Reset in the middle of a write: no response follows
    bus.S_AXI_AWADDR  = 5'h04;
    bus.S_AXI_WDATA   = 32'hF;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    op = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.S_AXI_BVALID) op++;
      @(negedge clk);
    end
    check("rst_mid_nob", op, 0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    check_read("rd_ier_rst_mid", 5'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
